// File: rtl/channel_scan_seq.sv
// -----------------------------------------------------------------------------
// channel_scan_seq
//
// Channel scan sequencer driving the 4-bit select of a downstream 4-to-16
// decoder. On start it latches a 16-bit channel mask, a dwell count and the
// continuous-mode flag. It then steps through the enabled channels, lowest
// index first, and holds each one for dwell+1 cycles. In single-sweep mode it
// returns to IDLE with a one-cycle done pulse. In continuous mode it wraps to
// the lowest enabled channel and keeps running. stop aborts a scan without a
// done pulse.
//
// Optional feature, enabled with `define SCAN_ONEHOT_OUT_EN:
//   adds a registered one-hot output q[15:0] = 1 << sel while sel_valid,
//   else 0. It updates on the same edge as sel.
// -----------------------------------------------------------------------------
module channel_scan_seq #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [15:0]        ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [3:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               done
`ifdef SCAN_ONEHOT_OUT_EN
    ,
    output logic [15:0]        q
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Result of a priority search: whether any bit was set, and the lowest index.
    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // Lowest set bit of a 16-bit vector. Purely combinational.
    function automatic pick_t lowest_set(input logic [15:0] m);
        pick_t r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) begin
                r.found = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

    state_t             state, state_n;
    logic [3:0]         sel_n;
    logic               done_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [15:0]        mask_q;
    logic               cont_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               load;

    logic [15:0]        mask_above;
    pick_t              next_above;
    pick_t              first_latched;
    pick_t              first_input;

    // Build the latched-mask bits strictly above the current channel,
    // then run the priority searches.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        mask_above = '0;
        for (int i = 0; i < 16; i++) begin
            mask_above[i] = mask_q[i] && (4'(i) > sel);
        end
        next_above    = lowest_set(mask_above);
        first_latched = lowest_set(mask_q);
        first_input   = lowest_set(ch_mask);
    end

    // Next-state and next-output logic of the scan FSM.
    always_comb begin
        state_n = state;
        sel_n   = sel;
        cnt_n   = cnt;
        done_n  = 1'b0;
        load    = 1'b0;

        unique case (state)
            IDLE: begin
                // start wins over stop in IDLE. stop alone is ignored here.
                if (start && first_input.found) begin
                    state_n = RUN;
                    sel_n   = first_input.idx;
                    cnt_n   = '0;
                    load    = 1'b1;
                end
            end

            RUN: begin
                if (stop) begin
                    // An abort suppresses any end-of-sweep done at this edge.
                    state_n = IDLE;
                    sel_n   = 4'd0;
                    cnt_n   = '0;
                end else if (cnt == dwell_q) begin
                    cnt_n = '0;
                    if (next_above.found) begin
                        sel_n = next_above.idx;
                    end else if (cont_q) begin
                        // Wrap. With a single-bit mask this re-enters the same
                        // channel, so sel_valid stays high.
                        sel_n = first_latched.idx;
                    end else begin
                        state_n = IDLE;
                        sel_n   = 4'd0;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + DWELL_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
                sel_n   = 4'd0;
                cnt_n   = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values no matter how the blocks are ordered.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Channel select, dwell counter and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel  <= 4'd0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            sel  <= sel_n;
            cnt  <= cnt_n;
            done <= done_n;
        end
    end

    // Scan configuration captured at start. It holds steady for the whole scan,
    // so input changes during RUN are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these are plain flops, not a memory array, so they reset
        // to a known zero like the rest of the state.
        if (!rst_n) begin
            mask_q  <= '0;
            cont_q  <= 1'b0;
            dwell_q <= '0;
        end else if (load) begin
            mask_q  <= ch_mask;
            cont_q  <= cont;
            dwell_q <= dwell;
        end
    end

    assign busy      = (state == RUN);
    assign sel_valid = (state == RUN);

`ifdef SCAN_ONEHOT_OUT_EN
    // One-hot copy of the select. It is registered from the same next values
    // as sel, so it changes on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (state_n == RUN) begin
            q <= 16'h0001 << sel_n;
        end else begin
            q <= '0;
        end
    end
`endif

endmodule

// File: doc/channel_scan_seq.md
Name: channel_scan_seq

Overview:
- Sequencer that sits directly upstream of the 4-to-16 shift decoder and drives its 4-bit select input.
- Steps through the channels enabled in a 16-bit mask, lowest index first, holding each channel for a programmable dwell time.
- Supports single-sweep and continuous (wrap-around) modes, with start/stop control and a done pulse.
- Typical use: time-multiplexed strobe/scan generation, where sel feeds the decoder and sel_valid gates the decoder output.

Parameters:
DWELL_W, 8, width of the dwell-count input; each channel is held for dwell+1 cycles.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level-sampled start request; honoured only in IDLE
stop  input  1  abort request; honoured only while busy
cont  input  1  1 = continuous wrap mode, 0 = single sweep; latched at start
ch_mask  input  16  channel enable mask; bit i set = channel i scanned; latched at start
dwell  input  DWELL_W  hold cycles minus one per channel; latched at start
sel  output  4  current channel index, feeds decoder select
sel_valid  output  1  sel is an active channel this cycle
busy  output  1  sequencer in RUN state
done  output  1  one-cycle pulse after a completed single sweep

Behaviour:
- Reset (async assert, sync release): state=IDLE, sel=0, sel_valid=0, busy=0, done=0, dwell counter=0, latched mask/cont/dwell=0.
- States: IDLE, RUN.
- IDLE -> RUN: start=1 and ch_mask!=0 sampled at edge T.
  - Latch ch_mask, dwell and cont at T.
  - At T+1: sel=lowest set bit of the mask, sel_valid=1, busy=1, dwell counter=0.
- start with ch_mask==0: ignored; remains IDLE, no done pulse.
- RUN dwell:
  - Counter increments each cycle.
  - When the counter equals the latched dwell, the next edge advances to the next set bit strictly above sel. No idle gap between channels.
  - Counter clears on each advance.
- End of mask (no set bit above sel):
  - cont=1: wrap to the lowest set bit and stay in RUN.
  - cont=0: next cycle state=IDLE, sel=0, sel_valid=0, busy=0, done=1 for exactly one cycle.
- Single-bit mask in continuous mode: the same channel is re-entered; sel_valid stays 1 continuously.
- stop=1 in RUN: next cycle IDLE, sel=0, sel_valid=0, busy=0. No done pulse.
  - stop overrides the end-of-sweep done if both occur at the same edge.
- stop in IDLE: ignored. start in RUN: ignored.
- start and stop both high in IDLE: start wins.
- Input changes to ch_mask, dwell or cont during RUN have no effect until the next start.
- Next-channel search: combinational 16-bit priority search over latched mask bits above sel; no multi-cycle search.
- Reset asserted mid-RUN: outputs return to reset values immediately (async); scan does not resume after release.
- Total single-sweep length = popcount(mask) x (dwell+1) cycles of sel_valid=1.

Optional Feature:
- Macro: SCAN_ONEHOT_OUT_EN.
- Defined: adds output port q[15:0], registered, updated on the same edge as sel.
  - q = 16'h0001 << sel when sel_valid=1, else 16'h0000.
  - Reset value 0.
  - Lets the block drive one-hot loads directly, bypassing the external decoder.
- Undefined: port q and its logic are absent. Remaining ports and timing are unchanged.

Test Plan:
1. ch_mask=16'h0025, dwell=1, cont=0, start pulse at T -> sel=0,0,2,2,5,5 with sel_valid=1 over T+1..T+6; T+7: sel_valid=0, busy=0, done=1 for one cycle.
2. ch_mask=16'hFFFF, dwell=0, cont=0 -> sel=0,1,...,15 on 16 consecutive cycles; done on the 17th cycle.
3. ch_mask=16'h8001, dwell=2, cont=1 -> pattern 0,0,0,15,15,15 repeats for 3 full wraps with no gap and no done. Assert stop -> next cycle sel_valid=0, busy=0, done=0.
4. ch_mask=16'h0000, start=1 -> busy stays 0, sel_valid 0, done 0. Then ch_mask=16'h0010 with start -> sel=4 for dwell+1 cycles, then done.
5. Mid-sweep with ch_mask=16'h00F0, dwell=3: change ch_mask to 16'h0001 and dwell to 0 -> sweep continues through channels 4..7 with 4 cycles each. Assert rst_n=0 mid-channel -> sel=0, sel_valid=0, busy=0 immediately.
6. With SCAN_ONEHOT_OUT_EN defined, run scenario 1 -> q=16'h0001,16'h0001,16'h0004,16'h0004,16'h0020,16'h0020, then 16'h0000.
